// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch stage that sits directly in front of the frontend decoder.
// It owns the fetch PC and drives the instruction-memory address. It captures
// the returning bytes, together with their PCs, in a small FIFO and hands them
// to the frontend on a valid/ready byte stream. A redirect from the middle end
// flushes everything and restarts fetch at the new PC.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  fetch PC loaded on reset
//
// Ports
//   clk          in   1   system clock
//   rst          in   1   synchronous, active-high reset (overrides redirect)
//   redirect     in   1   flush and restart fetch at redirect_pc
//   redirect_pc  in   16  new fetch PC, sampled while redirect=1
//   addr_i       out  16  instruction memory address (= fetch PC)
//   din_i        in   8   memory byte for the address issued last cycle
//   instr        out  8   head byte to the frontend
//   instr_pc     out  16  PC of the head byte
//   instr_valid  out  1   head byte valid
//   instr_ready  in   1   frontend accepts the head byte
//
// Configuration macro
//   FETCH_BYPASS_EN  when defined, a byte returning into an empty FIFO is
//                    presented to the frontend in the same cycle. If the
//                    frontend takes it, the byte is not written to the FIFO.
//                    This cuts the latency from two cycles to one.
// ----------------------------------------------------------------------------
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] addr_i,
   input  logic [7:0]  din_i,
   output logic [7:0]  instr,
   output logic [15:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW:0] DEPTH_V = (PW + 1)'(DEPTH);

   // Pointers carry an extra wrap bit.
   // empty: the pointers are equal.
   // full:  the MSBs differ and the lower bits are equal.
   logic [PW-1:0] rd_ptr_reg;
   logic [PW-1:0] wr_ptr_reg;
   logic [15:0]   fetch_pc_reg;
   logic [15:0]   tag_pc_reg;     // PC of the byte currently in flight
   logic          inflight_reg;   // a read was issued last cycle

   logic [7:0]    data_mem [DEPTH];
   logic [15:0]   pc_mem   [DEPTH];

   logic [PW-1:0] fifo_count;
   logic [PW-1:0] count_after_pop;
   logic [PW:0]   credit_used;
   logic          fifo_empty;
   logic          fifo_pop;
   logic          bypass_valid;
   logic          bypass_take;
   logic          push;
   logic          issue;

   assign fifo_count = wr_ptr_reg - rd_ptr_reg;
   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_pop   = !fifo_empty && instr_ready;

`ifdef FETCH_BYPASS_EN
   // The returning byte goes straight to the frontend when nothing is queued
   // ahead of it. A redirect discards the byte, so no bypass happens then.
   assign bypass_valid = fifo_empty && inflight_reg && !redirect;
`else
   assign bypass_valid = 1'b0;
`endif
   assign bypass_take = bypass_valid && instr_ready;

   // The returning byte is stored unless a redirect discards it or the
   // frontend consumed it through the bypass.
   assign push = inflight_reg && !redirect && !bypass_take;

   // Credit check: the entries left after this cycle's pop, plus the byte
   // still landing, must leave room for one more request. A byte consumed
   // through the bypass no longer needs an entry.
   assign count_after_pop = fifo_count - PW'(fifo_pop);
   assign credit_used     = {1'b0, count_after_pop}
                          + (PW + 1)'(inflight_reg && !bypass_take);
   assign issue           = !redirect && (credit_used < DEPTH_V);

   assign addr_i = fetch_pc_reg;

   // Head presentation. The outputs read as zero whenever nothing is valid.
   always_comb begin
      instr       = 8'h00;
      instr_pc    = 16'h0000;
      instr_valid = 1'b0;
      if (!fifo_empty) begin
         instr       = data_mem[rd_ptr_reg[AW-1:0]];
         instr_pc    = pc_mem[rd_ptr_reg[AW-1:0]];
         instr_valid = 1'b1;
      end else if (bypass_valid) begin
         instr       = din_i;
         instr_pc    = tag_pc_reg;
         instr_valid = 1'b1;
      end
   end

   // Control state. Reset outranks redirect, and redirect outranks any push,
   // pop or issue in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         inflight_reg <= 1'b0;
         fetch_pc_reg <= RESET_PC;
         tag_pc_reg   <= 16'h0000;
      end else if (redirect) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         inflight_reg <= 1'b0;
         fetch_pc_reg <= redirect_pc;
      end else begin
         if (fifo_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         inflight_reg <= issue;
         if (issue) begin
            tag_pc_reg   <= fetch_pc_reg;
            fetch_pc_reg <= fetch_pc_reg + 16'h0001;
         end
      end
   end

   // Storage is not reset. The empty flag masks any stale contents.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         data_mem[wr_ptr_reg[AW-1:0]] <= din_i;
         pc_mem[wr_ptr_reg[AW-1:0]]   <= tag_pc_reg;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue.
// - The memory model returns addr[7:0] one cycle after the address is issued.
// - After a reset or redirect to PC P, the reference stream is P, P+1, P+2, ...
//   with 16-bit wrap. Each entry carries byte = pc[7:0].
// - The stimulus loads that stream into a scoreboard queue.
// - An independent monitor pops the queue on every handshake and compares.
// - The monitor also checks that a head held with ready low stays stable.
// ----------------------------------------------------------------------------
module tb_fetch_queue;

   localparam int          DEPTH  = 4;
   localparam logic [15:0] RST_PC = 16'h0200;
`ifdef FETCH_BYPASS_EN
   localparam logic        BYP = 1'b1;
`else
   localparam logic        BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic [15:0] addr_i;
   logic [7:0]  din_i;
   logic [7:0]  instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;

   int errors = 0;
   int checks = 0;
   int delivered = 0;
   logic [15:0] last_pc = 16'h0000;

   logic [15:0] exp_q[$];

   logic        hold_prev = 1'b0;
   logic [7:0]  held_instr = 8'h00;
   logic [15:0] held_pc = 16'h0000;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .addr_i      (addr_i),
      .din_i       (din_i),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read instruction memory: mem[a] = a[7:0].
   always @(posedge clk) din_i <= addr_i[7:0];

   task automatic check16(input string name, input logic [15:0] act,
                          input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference stream: consecutive PCs from pc, with 16-bit wrap.
   task automatic load_stream(input logic [15:0] pc);
      exp_q.delete();
      for (int i = 0; i < 1500; i++) exp_q.push_back(pc + 16'(i));
   endtask

   task automatic do_redirect(input logic [15:0] pc);
      redirect    = 1'b1;
      redirect_pc = pc;
      step();
      redirect = 1'b0;
      load_stream(pc);
      check16("valid_after_redirect", {15'd0, instr_valid}, 16'h0000);
      check16("addr_after_redirect", addr_i, pc);
   endtask

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         hold_prev <= 1'b0;
      end else begin
         if (hold_prev) begin
            check16("hold_valid", {15'd0, instr_valid}, 16'h0001);
            check16("hold_instr", {8'h00, instr}, {8'h00, held_instr});
            check16("hold_pc", instr_pc, held_pc);
         end
         if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: got pc %h expected nothing", instr_pc);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               check16("sb_pc", instr_pc, e);
               check16("sb_byte", {8'h00, instr}, {8'h00, e[7:0]});
               delivered++;
               last_pc = instr_pc;
            end
         end
         hold_prev  <= instr_valid && !instr_ready && !redirect;
         held_instr <= instr;
         held_pc    <= instr_pc;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      logic [15:0] a0;
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      instr_ready = 1'b1;
      step(); step(); step();

      // Reset state
      check16("rst_valid", {15'd0, instr_valid}, 16'h0000);
      check16("rst_instr", {8'h00, instr}, 16'h0000);
      check16("rst_pc", instr_pc, 16'h0000);
      check16("rst_addr", addr_i, RST_PC);

      // 1: fetch after reset release, always ready
      rst = 1'b0;
      load_stream(RST_PC);
      check16("t1_c0_addr", addr_i, RST_PC);
      check16("t1_c0_valid", {15'd0, instr_valid}, 16'h0000);
      step();
      check16("t1_c1_addr", addr_i, RST_PC + 16'd1);
      check16("t1_c1_valid", {15'd0, instr_valid}, {15'd0, BYP});
      step();
      check16("t1_c2_valid", {15'd0, instr_valid}, 16'h0001);
      check16("t1_c2_addr", addr_i, RST_PC + 16'd2);
      for (int i = 3; i < 11; i++) begin
         step();
         check16("t1_stream_valid", {15'd0, instr_valid}, 16'h0001);
         check16("t1_stream_addr", addr_i, RST_PC + 16'(i));
      end

      // 2: stall for 10 cycles, then drain
      instr_ready = 1'b0;
      do_redirect(16'h0300);
      for (int i = 0; i < 10; i++) step();
      check16("t2_addr_stopped", addr_i, 16'h0300 + 16'(DEPTH));
      a0 = addr_i;
      step();
      check16("t2_addr_held", addr_i, a0);
      check16("t2_valid", {15'd0, instr_valid}, 16'h0001);
      d0 = delivered;
      instr_ready = 1'b1;
      for (int i = 0; i < DEPTH + 4; i++) step();
      check16("t2_drained", 16'(delivered - d0), 16'(DEPTH + 4));

      // 3: redirect with 3 bytes queued and 1 in flight
      instr_ready = 1'b0;
      do_redirect(16'h0400);
      for (int i = 0; i < 4; i++) step();
      check16("t3_addr_before", addr_i, 16'h0404);
      do_redirect(16'h1234);
      instr_ready = 1'b1;
      d0 = delivered;
      for (int i = 0; i < 10 && delivered == d0; i++) step();
      check16("t3_got_byte", {15'd0, delivered > d0}, 16'h0001);
      check16("t3_first_pc", last_pc, 16'h1234);

      // 4: PC wrap
      do_redirect(16'hFFFE);
      d0 = delivered;
      for (int i = 0; i < 8; i++) step();
      check16("t4_count", {15'd0, (delivered - d0) >= 4}, 16'h0001);

      // 5: random ready for 1000 cycles
      d0 = delivered;
      for (int i = 0; i < 1000; i++) begin
         instr_ready = 1'($urandom_range(0, 1));
         step();
      end
      check16("t5_progress", {15'd0, (delivered - d0) > 200}, 16'h0001);

      // 6: reset while full
      instr_ready = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check16("t6_full_valid", {15'd0, instr_valid}, 16'h0001);
      rst = 1'b1;
      step();
      check16("t6_valid", {15'd0, instr_valid}, 16'h0000);
      check16("t6_addr", addr_i, RST_PC);
      check16("t6_instr", {8'h00, instr}, 16'h0000);
      check16("t6_pc", instr_pc, 16'h0000);
      rst = 1'b0;
      load_stream(RST_PC);
      instr_ready = 1'b1;
      d0 = delivered;
      for (int i = 0; i < 20; i++) step();
      check16("t6_restart", {15'd0, (delivered - d0) >= 17}, 16'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
